// File: rtl/fu_btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters,
// round-robin replacement and a one-set-per-cycle invalidate sweep.
module fu_btb_assoc #(
  parameter int SETS     = 64,
  parameter int WAYS     = 2,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_fetch,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush_req,
  output logic        flush_busy
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 32 - IDX_BITS - 2;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                                   state_q, state_d;
  logic [IDX_BITS-1:0]                      cnt_q, cnt_d;
  logic [SETS-1:0][WAYS-1:0]                valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][TAG_BITS-1:0]  tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][31:0]          tgt_q, tgt_d;
  logic [SETS-1:0][WAYS-1:0][CTR_BITS-1:0]  ctr_q, ctr_d;
  logic [SETS-1:0][WAY_BITS-1:0]            rr_q, rr_d;

  function automatic logic [CTR_BITS-1:0] sat_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  function automatic logic [WAY_BITS-1:0] rr_adv(input logic [WAY_BITS-1:0] r);
    return (WAYS == 1) ? '0 : r + WAY_BITS'(1);
  endfunction

  logic [IDX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                f_hit, u_hit, inv_found;
  logic [WAY_BITS-1:0] f_way, u_way, inv_way, victim;

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    f_idx     = pc_fetch[IDX_BITS+1:2];
    f_tag     = pc_fetch[31:IDX_BITS+2];
    u_idx     = upd_pc[IDX_BITS+1:2];
    u_tag     = upd_pc[31:IDX_BITS+2];
    f_hit     = 1'b0;
    f_way     = '0;
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = WAY_BITS'(w);
      end
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag) begin
        u_hit = 1'b1;
        u_way = WAY_BITS'(w);
      end
      if (!valid_q[u_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_BITS'(w);
      end
    end
  end

  assign flush_busy  = (state_q == SWEEP);
  assign pred_hit    = f_hit && !flush_busy;
  assign pred_taken  = pred_hit && ctr_q[f_idx][f_way][CTR_BITS-1];
  assign pred_target = pred_hit ? tgt_q[f_idx][f_way] : 32'h0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    rr_d    = rr_q;
    victim  = inv_found ? inv_way : rr_q[u_idx];
    case (state_q)
      IDLE: begin
        // A flush request in the same cycle as an update drops the update.
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end else if (upd_valid) begin
          if (u_hit) begin
            ctr_d[u_idx][u_way] = upd_taken ? sat_inc(ctr_q[u_idx][u_way])
                                            : sat_dec(ctr_q[u_idx][u_way]);
            if (upd_taken) tgt_d[u_idx][u_way] = upd_target;
          end else if (upd_taken) begin
            if (!inv_found) rr_d[u_idx] = rr_adv(rr_q[u_idx]);
            valid_d[u_idx][victim] = 1'b1;
            tag_d[u_idx][victim]   = u_tag;
            tgt_d[u_idx][victim]   = upd_target;
            ctr_d[u_idx][victim]   = CTR_INIT;
          end
        end
      end
      SWEEP: begin
        valid_d[cnt_q] = '0;
        rr_d[cnt_q]    = '0;
        cnt_d          = cnt_q + IDX_BITS'(1);
        if (cnt_q == IDX_BITS'(SETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      tag_q   <= '0;
      tgt_q   <= '0;
      ctr_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      ctr_q   <= ctr_d;
      rr_q    <= rr_d;
    end
  end

endmodule
